image_mem_reader: RTL and testbench
===================================

# image_mem_reader

Frame scanner on the read side of the 24-bit image memory. On `start` it walks addresses 0 to N_PIXELS-1 in raster order and drives the memory's synchronous read port, which has 1-cycle latency. It returns each word as a pixel on a valid/ready stream with start-of-frame, end-of-line and end-of-frame markers. It sits between the image memory and the display/output pipeline and sustains one pixel per clock when the sink never stalls.

## Interface
- `WORD_W`, 24: pixel/memory word width; R in [23:16], G in [15:8], B in [7:0].
- `H_PIXELS`, 32: pixels per line.
- `V_LINES`, 16: lines per frame; N_PIXELS = H_PIXELS*V_LINES (512).
- `ADDR_W`, 9: memory address width, equal to clog2(N_PIXELS).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a frame; sampled only in IDLE.
- `mem_addr` out ADDR_W: registered read address to the image memory.
- `mem_dout` in WORD_W: memory read data for the address held at the previous edge.
- `mem_we` out 1: tied 0; the reader never writes.
- `pix_data` out WORD_W: pixel word.
- `pix_valid` out 1: pixel available.
- `pix_ready` in 1: sink accepts; transfer happens when valid && ready.
- `pix_sof` out 1: qualifies pixel 0.
- `pix_eol` out 1: qualifies the last pixel of each line (x == H_PIXELS-1).
- `pix_eof` out 1: qualifies pixel N_PIXELS-1.
- `busy` out 1: high from the `start` acceptance edge until the last pixel has transferred.
- `frame_done` out 1: one-cycle pulse in the cycle after the last pixel transfers.

## Operation
- States:
  - IDLE: wait for `start`.
  - RUN: issue reads.
  - DRAIN: all reads issued; empty the buffer.
- IDLE -> RUN on `start`. RUN -> DRAIN when address N_PIXELS-1 is issued. DRAIN -> IDLE when the eof pixel transfers.
- Read issue rule: issue when (buffer occupancy + in-flight reads - pop this cycle) < 2. Each issue increments `mem_addr`. At most 1 read is in flight.
- Returned data is captured into a 2-entry output buffer together with its sof/eol/eof flags, computed from the issued address.
- With `pix_valid`=1 and `pix_ready`=0, `pix_data` and all flags hold stable. No pixel is ever dropped or duplicated.
- `start` is ignored outside IDLE. A `start` in the same cycle as the eof transfer is ignored; it is accepted only once back in IDLE.
- Reset values: `mem_addr`=0, `pix_valid`=0, `pix_data`=0, flags=0, `busy`=0, `frame_done`=0, state IDLE.
- Asserting reset mid-frame clears the buffer, discards any in-flight read and returns to IDLE. No partial-frame markers are emitted afterward.
- Address counter is ADDR_W bits and stops at N_PIXELS-1; it never wraps in single-frame mode.

## Timing
- `start` is sampled at edge E. `mem_addr`=0 after E. `mem_dout`=mem[0] after E+1. Pixel 0 is visible (`pix_valid`=1, `pix_sof`=1) after E+2.
- With `pix_ready` held 1, pixels transfer on consecutive cycles. The last pixel transfers at edge E+2+N_PIXELS. `frame_done` is high for the cycle after that edge, and `busy` falls at that same edge.
- Resumption after a stall: the pending buffered pixel transfers on the first cycle `pix_ready` returns to 1, with no bubble.

## Configuration
- `IMAGE_MEM_READER_CONTINUOUS_EN` defined:
  - After issuing address N_PIXELS-1, the address wraps to 0 and RUN continues; there is no DRAIN.
  - `frame_done` pulses after every eof transfer. `busy` stays 1 until reset.
  - Only the first `start` is needed.
- Undefined: single-frame behaviour as above; each frame needs a new `start`.

## Structure
- Package `image_mem_pkg` holds:
  - `WORD_W`, `H_PIXELS`, `V_LINES`, `N_PIXELS`, `ADDR_W` constants.
  - `pixel_t` packed struct {r, g, b} of 8 bits each.
  - `pix_flags_t` {sof, eol, eof}.
  - Reader state enum.
- Sub-module `pix_skid_buf`: 2-entry valid/ready buffer carrying a `pixel_t` plus `pix_flags_t`, with occupancy output used by the issue rule.

## Test plan
- Preload mem[i]=i, pulse `start`, `pix_ready`=1:
  - 512 pixels 0..511 on consecutive cycles; first `pix_valid` 2 cycles after `start`.
  - sof on 0; eol on 31, 63, …, 511; eof on 511.
  - `frame_done` one cycle after; `busy` low.
- Random `pix_ready` (50%): identical ordered sequence, no drops or duplicates; data and flags stable whenever valid && !ready.
- `pix_ready`=0 for 20 cycles after pixel 0 is presented: pixel 0 held, at most 1 read in flight, `mem_addr` ≤ 2; resumes with pixel 1 immediately after.
- Pulse `start` during RUN and again in the eof transfer cycle: ignored, exactly one frame output.
- Assert `rst_n`=0 at pixel 100: all outputs at reset values. A new `start` then produces pixel 0 with sof and no stale data.
- With `IMAGE_MEM_READER_CONTINUOUS_EN`: two back-to-back frames with no gap (pixel 511 then pixel 0 with sof), and `frame_done` pulses twice.

Source files
------------

// File: rtl/image_mem_reader_pkg.sv
// Shared types and constants for the image memory frame reader.
// The build macro IMAGE_MEM_READER_CONTINUOUS_EN changes nothing here; it only affects image_mem_reader.
package image_mem_pkg;

    localparam int WORD_W   = 24;
    localparam int H_PIXELS = 32;
    localparam int V_LINES  = 16;
    localparam int N_PIXELS = H_PIXELS * V_LINES;
    localparam int ADDR_W   = $clog2(N_PIXELS);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIXELS - 1);

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } pix_flags_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } rd_state_t;

    // Raster markers for a linear pixel address.
    function automatic pix_flags_t flags_of(input logic [ADDR_W-1:0] addr);
        pix_flags_t f;
        f.sof = (addr == '0);
        f.eol = ((int'(addr) % H_PIXELS) == (H_PIXELS - 1));
        f.eof = (addr == LAST_ADDR);
        return f;
    endfunction

endpackage

// File: rtl/image_mem_reader_if.sv
// Memory read port plus pixel stream seen by the frame reader.
// master: the reader side; slave: memory + sink side.
interface image_mem_reader_if;

    logic [image_mem_pkg::ADDR_W-1:0] mem_addr;
    logic [image_mem_pkg::WORD_W-1:0] mem_dout;
    logic                             mem_we;
    logic [image_mem_pkg::WORD_W-1:0] pix_data;
    logic                             pix_valid;
    logic                             pix_ready;
    logic                             pix_sof;
    logic                             pix_eol;
    logic                             pix_eof;

    modport master (
        output mem_addr, mem_we, pix_data, pix_valid, pix_sof, pix_eol, pix_eof,
        input  mem_dout, pix_ready
    );

    modport slave (
        input  mem_addr, mem_we, pix_data, pix_valid, pix_sof, pix_eol, pix_eof,
        output mem_dout, pix_ready
    );

endinterface

// File: rtl/image_mem_reader_pix_skid_buf.sv
// pix_skid_buf: 2-entry valid/ready FIFO for pixels and their raster flags.
// The producer never pushes into a full buffer; occupancy is exported so it can
// throttle its reads. Flags read as zero while the buffer is empty.
module pix_skid_buf
    import image_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  pixel_t     in_pix,
    input  pix_flags_t in_flags,
    output logic       out_valid,
    input  logic       out_ready,
    output pixel_t     out_pix,
    output pix_flags_t out_flags,
    output logic [1:0] occ
);

    pixel_t     pix_q [2];
    pix_flags_t flg_q [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] cnt;
    logic       pop;

    assign pop       = out_valid & out_ready;
    assign out_valid = (cnt != 2'd0);
    assign out_pix   = pix_q[rd_ptr];
    assign out_flags = out_valid ? flg_q[rd_ptr] : '0;
    assign occ       = cnt;

    // Entry storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                pix_q[i] <= '0;
                flg_q[i] <= '0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (in_valid) begin
                pix_q[wr_ptr] <= in_pix;
                flg_q[wr_ptr] <= in_flags;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({in_valid, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/image_mem_reader.sv
// image_mem_reader: raster-order frame scanner on the image memory read port.
// Reads have one cycle of latency; each returned word enters a 2-entry buffer
// tagged with sof/eol/eof derived from the address that was issued.
// Build macro IMAGE_MEM_READER_CONTINUOUS_EN: address wraps after the last pixel
// and frames repeat without gaps until reset.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing reads
// DRAIN | all reads issued, emptying the buffer
module image_mem_reader
    import image_mem_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    image_mem_reader_if.master bus,
    output logic               busy,
    output logic               frame_done
);

    rd_state_t         state;
    rd_state_t         state_n;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] iss_addr_q;
    logic              inflight_q;
    logic              issue;
    logic              pop;
    logic [2:0]        budget;

    logic       buf_valid;
    pixel_t     buf_pix;
    pix_flags_t buf_flags;
    logic [1:0] occ;

    // Slots committed after this edge: buffered + arriving - leaving.
    assign pop    = buf_valid & bus.pix_ready;
    assign budget = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and read-issue decision.
    always_comb begin
        state_n = state;
        issue   = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_n = RUN;
            end
            RUN: begin
                issue = (budget < 3'd2);
`ifndef IMAGE_MEM_READER_CONTINUOUS_EN
                if (issue && (addr_q == LAST_ADDR)) state_n = DRAIN;
`endif
            end
            DRAIN: begin
                if (pop && buf_flags.eof) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Read address counter and in-flight tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            iss_addr_q <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) iss_addr_q <= addr_q;
            if ((state == IDLE) && start) begin
                addr_q <= '0;
            end else if (issue) begin
                if (addr_q != LAST_ADDR) begin
                    addr_q <= addr_q + ADDR_W'(1);
                end else begin
`ifdef IMAGE_MEM_READER_CONTINUOUS_EN
                    addr_q <= '0;
`else
                    addr_q <= addr_q;
`endif
                end
            end
        end
    end

    // End-of-frame pulse, one cycle after the eof pixel leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= pop & buf_flags.eof;
        end
    end

    pix_skid_buf u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inflight_q),
        .in_pix    (pixel_t'(bus.mem_dout)),
        .in_flags  (flags_of(iss_addr_q)),
        .out_valid (buf_valid),
        .out_ready (bus.pix_ready),
        .out_pix   (buf_pix),
        .out_flags (buf_flags),
        .occ       (occ)
    );

    assign bus.mem_addr  = addr_q;
    assign bus.mem_we    = 1'b0;
    assign bus.pix_data  = buf_pix;
    assign bus.pix_valid = buf_valid;
    assign bus.pix_sof   = buf_flags.sof;
    assign bus.pix_eol   = buf_flags.eol;
    assign bus.pix_eof   = buf_flags.eof;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_image_mem_reader.sv
// Testbench for image_mem_reader: behavioural memory, stream collector and
// per-scenario checks against a raster-order reference (pixel k = mem[k]).
module tb_image_mem_reader;
    import image_mem_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic frame_done;

    image_mem_reader_if bus ();

    image_mem_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    logic [WORD_W-1:0] mem [N_PIXELS];
    always @(posedge clk) bus.mem_dout <= mem[bus.mem_addr];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int fd_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (frame_done) fd_cnt <= fd_cnt + 1;

    logic [WORD_W-1:0] got_data [$];
    logic [2:0]        got_flg  [$];
    int                got_edge [$];
    int                first_valid_cyc;
    int                stab_err;
    int                max_stall_addr;

    function automatic logic [2:0] exp_flg(input int k);
        return {k == 0, (k % H_PIXELS) == (H_PIXELS - 1), k == (N_PIXELS - 1)};
    endfunction

    function automatic int count_bad();
        int bad = 0;
        for (int k = 0; k < got_data.size() && k < N_PIXELS; k++)
            if (got_data[k] !== mem[k] || got_flg[k] !== exp_flg(k)) bad++;
        return bad;
    endfunction

    task automatic fill_mem(input bit ramp);
        for (int i = 0; i < N_PIXELS; i++)
            mem[i] = ramp ? WORD_W'(i) : WORD_W'($urandom);
    endtask

    // Start accepted at edge E; returns E as the cycle count seen at the following negedge.
    task automatic pulse_start(output int e);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e = cyc;
    endtask

    // mode 0: ready=1, 1: random ready, 2: 20-cycle stall on pixel 0.
    task automatic collect(input int mode, input int stop_at, input int start_at,
                           input bit start_eof, output bit timed_out);
        bit                held;
        logic [WORD_W-1:0] h_data;
        logic [2:0]        h_flg;
        int                stall_left;
        bit                done;
        got_data.delete();
        got_flg.delete();
        got_edge.delete();
        first_valid_cyc = -1;
        stab_err        = 0;
        max_stall_addr  = 0;
        held            = 1'b0;
        h_data          = '0;
        h_flg           = '0;
        stall_left      = 20;
        done            = 1'b0;
        for (int c = 0; c < 4000 && !done; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (held && (!bus.pix_valid || bus.pix_data !== h_data ||
                         {bus.pix_sof, bus.pix_eol, bus.pix_eof} !== h_flg))
                stab_err++;
            case (mode)
                1:       bus.pix_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (bus.pix_valid && got_data.size() == 0 && stall_left > 0) begin
                        bus.pix_ready = 1'b0;
                        stall_left--;
                        if (int'(bus.mem_addr) > max_stall_addr) max_stall_addr = int'(bus.mem_addr);
                    end else begin
                        bus.pix_ready = 1'b1;
                    end
                end
                default: bus.pix_ready = 1'b1;
            endcase
            if (first_valid_cyc < 0 && bus.pix_valid) first_valid_cyc = cyc;
            if (bus.pix_valid && bus.pix_ready) begin
                got_data.push_back(bus.pix_data);
                got_flg.push_back({bus.pix_sof, bus.pix_eol, bus.pix_eof});
                got_edge.push_back(cyc + 1);
                if (bus.pix_eof) begin
                    done = 1'b1;
                    if (start_eof) start = 1'b1;
                end
                if (got_data.size() == start_at) start = 1'b1;
                if (got_data.size() == stop_at) done = 1'b1;
            end
            held   = bus.pix_valid && !bus.pix_ready;
            h_data = bus.pix_data;
            h_flg  = {bus.pix_sof, bus.pix_eol, bus.pix_eof};
        end
        timed_out = !done;
    endtask

    task automatic test_reset();
        bus.pix_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.pix_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b exp=0", bus.pix_valid); end
        checks++; if (bus.pix_data !== '0) begin errors++; $display("FAIL rst_data got=%h exp=0", bus.pix_data); end
        checks++; if ({bus.pix_sof, bus.pix_eol, bus.pix_eof} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b exp=000", {bus.pix_sof, bus.pix_eol, bus.pix_eof}); end
        checks++; if (busy !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL rst_busy_done got=%b%b exp=00", busy, frame_done); end
        checks++; if (bus.mem_addr !== '0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_addr_we got=%0d/%0b exp=0/0", bus.mem_addr, bus.mem_we); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.pix_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_quiet got valid=%0b busy=%0b exp 0 0", bus.pix_valid, busy); end
    endtask

`ifndef IMAGE_MEM_READER_CONTINUOUS_EN
    task automatic test_full_rate();
        int e;
        bit to;
        fill_mem(1'b1);
        pulse_start(e);
        checks++; if (bus.mem_addr !== '0 || busy !== 1'b1) begin errors++; $display("FAIL fr_accept got addr=%0d busy=%0b exp 0 1", bus.mem_addr, busy); end
        collect(0, -1, -1, 1'b0, to);
        checks++; if (to) begin errors++; $display("FAIL fr_timeout got=timeout exp=eof"); end
        checks++; if (got_data.size() != N_PIXELS) begin errors++; $display("FAIL fr_count got=%0d exp=%0d", got_data.size(), N_PIXELS); end
        checks++; if (count_bad() != 0) begin errors++; $display("FAIL fr_content bad_pixels=%0d exp=0", count_bad()); end
        checks++; if (first_valid_cyc != e + 2) begin errors++; $display("FAIL fr_first_valid got=%0d exp=%0d", first_valid_cyc, e + 2); end
        checks++; if (got_edge.size() == N_PIXELS && got_edge[N_PIXELS-1] != e + 2 + N_PIXELS) begin errors++; $display("FAIL fr_last_edge got=%0d exp=%0d", got_edge[N_PIXELS-1], e + 2 + N_PIXELS); end
        checks++; if (got_edge.size() == N_PIXELS && got_edge[N_PIXELS-1] - got_edge[0] != N_PIXELS - 1) begin errors++; $display("FAIL fr_gapless span=%0d exp=%0d", got_edge[N_PIXELS-1] - got_edge[0], N_PIXELS - 1); end
        @(negedge clk);
        checks++; if (frame_done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL fr_done got done=%0b busy=%0b exp 1 0", frame_done, busy); end
        @(negedge clk);
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL fr_done_pulse got=%0b exp=0", frame_done); end
    endtask

    task automatic test_random_ready();
        int e;
        bit to;
        fill_mem(1'b0);
        pulse_start(e);
        collect(1, -1, -1, 1'b0, to);
        bus.pix_ready = 1'b1;
        checks++; if (to) begin errors++; $display("FAIL rr_timeout got=timeout exp=eof"); end
        checks++; if (got_data.size() != N_PIXELS) begin errors++; $display("FAIL rr_count got=%0d exp=%0d", got_data.size(), N_PIXELS); end
        checks++; if (count_bad() != 0) begin errors++; $display("FAIL rr_content bad_pixels=%0d exp=0", count_bad()); end
        checks++; if (stab_err != 0) begin errors++; $display("FAIL rr_hold unstable_cycles=%0d exp=0", stab_err); end
        @(negedge clk);
        checks++; if (frame_done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rr_done got done=%0b busy=%0b exp 1 0", frame_done, busy); end
    endtask

    task automatic test_stall();
        int e;
        bit to;
        fill_mem(1'b0);
        pulse_start(e);
        collect(2, -1, -1, 1'b0, to);
        checks++; if (to || got_data.size() != N_PIXELS) begin errors++; $display("FAIL st_count got=%0d exp=%0d", got_data.size(), N_PIXELS); end
        checks++; if (count_bad() != 0) begin errors++; $display("FAIL st_content bad_pixels=%0d exp=0", count_bad()); end
        checks++; if (stab_err != 0) begin errors++; $display("FAIL st_hold unstable_cycles=%0d exp=0", stab_err); end
        checks++; if (max_stall_addr > 2) begin errors++; $display("FAIL st_addr got=%0d exp<=2", max_stall_addr); end
        checks++; if (got_edge.size() > 1 && (got_edge[0] != e + 23 || got_edge[1] != got_edge[0] + 1)) begin errors++; $display("FAIL st_resume got=%0d,%0d exp=%0d,%0d", got_edge[0], got_edge[1], e + 23, e + 24); end
        checks++; if (got_edge.size() == N_PIXELS && got_edge[N_PIXELS-1] != e + 22 + N_PIXELS) begin errors++; $display("FAIL st_last_edge got=%0d exp=%0d", got_edge[N_PIXELS-1], e + 22 + N_PIXELS); end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        int e;
        int extra;
        bit to;
        fill_mem(1'b0);
        pulse_start(e);
        collect(0, -1, 100, 1'b1, to);
        @(negedge clk);
        start = 1'b0;
        checks++; if (to || got_data.size() != N_PIXELS) begin errors++; $display("FAIL si_count got=%0d exp=%0d", got_data.size(), N_PIXELS); end
        checks++; if (count_bad() != 0) begin errors++; $display("FAIL si_content bad_pixels=%0d exp=0", count_bad()); end
        checks++; if (frame_done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL si_done got done=%0b busy=%0b exp 1 0", frame_done, busy); end
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.pix_valid || busy) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL si_second_frame active_cycles=%0d exp=0", extra); end
    endtask

    task automatic test_reset_mid();
        int e;
        int stale;
        bit to;
        fill_mem(1'b0);
        pulse_start(e);
        collect(0, 100, -1, 1'b0, to);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.pix_valid !== 1'b0 || bus.pix_data !== '0) begin errors++; $display("FAIL rm_stream got valid=%0b data=%h exp 0 0", bus.pix_valid, bus.pix_data); end
        checks++; if ({bus.pix_sof, bus.pix_eol, bus.pix_eof} !== 3'b000 || busy !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL rm_ctrl got flags=%b busy=%0b done=%0b exp 000 0 0", {bus.pix_sof, bus.pix_eol, bus.pix_eof}, busy, frame_done); end
        checks++; if (bus.mem_addr !== '0) begin errors++; $display("FAIL rm_addr got=%0d exp=0", bus.mem_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.pix_valid || bus.pix_eof || busy) stale++;
        end
        checks++; if (stale != 0) begin errors++; $display("FAIL rm_stale active_cycles=%0d exp=0", stale); end
        fill_mem(1'b0);
        pulse_start(e);
        collect(0, -1, -1, 1'b0, to);
        checks++; if (to || got_data.size() != N_PIXELS) begin errors++; $display("FAIL rm_count got=%0d exp=%0d", got_data.size(), N_PIXELS); end
        checks++; if (count_bad() != 0) begin errors++; $display("FAIL rm_content bad_pixels=%0d exp=0", count_bad()); end
        checks++; if (first_valid_cyc != e + 2) begin errors++; $display("FAIL rm_first_valid got=%0d exp=%0d", first_valid_cyc, e + 2); end
        @(negedge clk);
    endtask
`else
    task automatic test_continuous();
        int e;
        int last1;
        int bad1;
        int fd0;
        bit to;
        fill_mem(1'b1);
        fd0 = fd_cnt;
        pulse_start(e);
        collect(0, -1, -1, 1'b0, to);
        bad1  = count_bad();
        last1 = (got_edge.size() > 0) ? got_edge[got_edge.size()-1] : -1;
        checks++; if (to || got_data.size() != N_PIXELS) begin errors++; $display("FAIL ct_count1 got=%0d exp=%0d", got_data.size(), N_PIXELS); end
        checks++; if (bad1 != 0) begin errors++; $display("FAIL ct_content1 bad_pixels=%0d exp=0", bad1); end
        checks++; if (last1 != e + 2 + N_PIXELS) begin errors++; $display("FAIL ct_last1 got=%0d exp=%0d", last1, e + 2 + N_PIXELS); end
        collect(0, -1, -1, 1'b0, to);
        checks++; if (to || got_data.size() != N_PIXELS) begin errors++; $display("FAIL ct_count2 got=%0d exp=%0d", got_data.size(), N_PIXELS); end
        checks++; if (count_bad() != 0) begin errors++; $display("FAIL ct_content2 bad_pixels=%0d exp=0", count_bad()); end
        checks++; if (got_edge.size() > 0 && got_edge[0] != last1 + 1) begin errors++; $display("FAIL ct_no_gap got=%0d exp=%0d", got_edge[0], last1 + 1); end
        repeat (2) @(negedge clk);
        checks++; if (fd_cnt - fd0 != 2) begin errors++; $display("FAIL ct_done_pulses got=%0d exp=2", fd_cnt - fd0); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ct_busy got=%0b exp=1", busy); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || bus.pix_valid !== 1'b0) begin errors++; $display("FAIL ct_reset got busy=%0b valid=%0b exp 0 0", busy, bus.pix_valid); end
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pix_ready = 1'b0;
        test_reset();
`ifndef IMAGE_MEM_READER_CONTINUOUS_EN
        test_full_rate();
        test_random_ready();
        test_stall();
        test_start_ignored();
        test_reset_mid();
`else
        test_continuous();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
